// File: rtl/pe_link_pkg.sv
// Shared definitions for the overlay mesh link: word layout, field positions
// and a helper that packs a link word from its fields.
package pe_link_pkg;

    localparam int LINK_WIDTH      = 130;
    localparam int DATA_WIDTH      = 128;
    localparam int LINK_VALID_BIT  = 129;
    localparam int LINK_LAST_BIT   = 128;
    localparam int LINK_CREDIT_BIT = 129;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } link_word_t;

    function automatic logic [LINK_WIDTH-1:0] pack_link_word(
        input logic                  valid,
        input logic                  last,
        input logic [DATA_WIDTH-1:0] data
    );
        link_word_t w;
        w.valid = valid;
        w.last  = last;
        w.data  = data;
        return w;
    endfunction

endpackage

// File: rtl/pe_link_fifo.sv
// Synchronous first-word-fall-through FIFO; head shows the oldest entry.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module pe_link_fifo
    import pe_link_pkg::*;
#(
    parameter int WIDTH     = DATA_WIDTH + 1,
    parameter int ADDR_BITS = 3,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_link_rx_sink.sv
// Terminating receiver for the mesh link: registers incoming words, buffers
// them in a FIFO for a ready/valid consumer and returns one credit per pop.
module pe_link_rx_sink
    import pe_link_pkg::*;
#(
    parameter int FIFO_ADDR_BITS = 3,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [LINK_WIDTH-1:0] in_from_east,
    output logic [LINK_WIDTH-1:0] out_to_east,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  overflow_err
);

    logic [LINK_WIDTH-1:0] in_reg;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [DATA_WIDTH:0]   held_word;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  word_valid;
    logic                  pop;
    logic                  emit;
    logic [CNT_WIDTH-1:0]  credit_pend;

    assign word_valid = in_reg[LINK_VALID_BIT];
    assign m_valid    = !fifo_empty && ap_start;
    assign pop        = m_valid && m_ready;
    assign emit       = ap_start && (credit_pend != '0);

    // When empty the stream keeps showing the last word that left the FIFO.
    assign m_data = fifo_empty ? held_word[DATA_WIDTH-1:0] : fifo_head[DATA_WIDTH-1:0];
    assign m_last = fifo_empty ? held_word[DATA_WIDTH]     : fifo_head[DATA_WIDTH];

    pe_link_fifo #(
        .WIDTH     (DATA_WIDTH + 1),
        .ADDR_BITS (FIFO_ADDR_BITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (word_valid),
        .push_data ({in_reg[LINK_LAST_BIT], in_reg[DATA_WIDTH-1:0]}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_reg       <= '0;
            held_word    <= '0;
            overflow_err <= 1'b0;
        end else begin
            in_reg <= in_from_east;
            if (pop) begin
                held_word <= fifo_head;
            end
            if (word_valid && fifo_full && !pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // A pop and a credit emission in the same cycle cancel out in the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_pend <= '0;
            out_to_east <= '0;
        end else begin
            case ({pop, emit})
                2'b10:   credit_pend <= credit_pend + 1'b1;
                2'b01:   credit_pend <= credit_pend - 1'b1;
                default: credit_pend <= credit_pend;
            endcase
            out_to_east                  <= '0;
            out_to_east[LINK_CREDIT_BIT] <= emit;
        end
    end

endmodule

// File: tb/tb_pe_link_rx_sink.sv
// Directed bench for pe_link_rx_sink: latency, full/overflow, ap_start stalls,
// credit return and asynchronous reset, with hand-computed expectations.
module tb_pe_link_rx_sink;
    import pe_link_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  ap_start;
    logic [LINK_WIDTH-1:0] in_from_east;
    logic [LINK_WIDTH-1:0] out_to_east;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [3:0]            occupancy;
    logic                  overflow_err;

    int total;
    int bad;
    int pulses;

    localparam logic [LINK_WIDTH-1:0] CREDIT_WORD = {1'b1, 129'b0};

    pe_link_rx_sink dut (
        .clk          (clk),
        .reset        (reset),
        .ap_start     (ap_start),
        .in_from_east (in_from_east),
        .out_to_east  (out_to_east),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Credit pulses last exactly one cycle, so one sample per cycle counts each once.
    always @(negedge clk) begin
        if (!reset && out_to_east[LINK_CREDIT_BIT]) begin
            pulses <= pulses + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic last, input logic [DATA_WIDTH-1:0] data);
        in_from_east = pack_link_word(valid, last, data);
    endtask

    task automatic checkOutput(input string tag, input logic [LINK_WIDTH-1:0] observed,
                               input logic [LINK_WIDTH-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        pulses       = 0;
        reset        = 1'b1;
        ap_start     = 1'b1;
        m_ready      = 1'b1;
        in_from_east = '0;
        tick();
        tick();
        checkOutput("rst_valid",     LINK_WIDTH'(m_valid), '0);
        checkOutput("rst_data",      LINK_WIDTH'(m_data), '0);
        checkOutput("rst_last",      LINK_WIDTH'(m_last), '0);
        checkOutput("rst_occ",       LINK_WIDTH'(occupancy), '0);
        checkOutput("rst_ovf",       LINK_WIDTH'(overflow_err), '0);
        checkOutput("rst_out",       out_to_east, '0);
        reset = 1'b0;
        tick();

        // Single word: captured at edge 0, readable before edge 2, credit after edge 3.
        $display("[TB] single word latency");
        applyStimulus(1'b1, 1'b1, 128'h1234);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t1_nobypass",   LINK_WIDTH'(m_valid), '0);
        tick();
        checkOutput("t1_valid",      LINK_WIDTH'(m_valid), 1);
        checkOutput("t1_data",       LINK_WIDTH'(m_data), 130'h1234);
        checkOutput("t1_last",       LINK_WIDTH'(m_last), 1);
        checkOutput("t1_occ",        LINK_WIDTH'(occupancy), 1);
        tick();
        checkOutput("t1_popped",     LINK_WIDTH'(m_valid), '0);
        checkOutput("t1_hold",       LINK_WIDTH'(m_data), 130'h1234);
        checkOutput("t1_nocredit",   out_to_east, '0);
        tick();
        checkOutput("t1_credit",     out_to_east, CREDIT_WORD);
        tick();
        checkOutput("t1_credit_end", out_to_east, '0);
        checkOutput("t1_pulses",     LINK_WIDTH'(pulses), 1);

        // Burst of 8 fills the FIFO, a 9th word overflows, then drain in order.
        $display("[TB] burst fill, overflow and drain");
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, i == 7, DATA_WIDTH'(32'h100 + i));
            tick();
        end
        applyStimulus(1'b1, 1'b0, 128'h1ff);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t2_occ_full",   LINK_WIDTH'(occupancy), 8);
        checkOutput("t2_no_ovf",     LINK_WIDTH'(overflow_err), '0);
        checkOutput("t2_no_credit",  LINK_WIDTH'(pulses), 1);
        tick();
        checkOutput("t2_ovf",        LINK_WIDTH'(overflow_err), 1);
        checkOutput("t2_occ_sat",    LINK_WIDTH'(occupancy), 8);
        checkOutput("t2_head",       LINK_WIDTH'(m_data), 130'h100);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t2_drain_valid%0d", i), LINK_WIDTH'(m_valid), 1);
            checkOutput($sformatf("t2_drain_data%0d", i),  LINK_WIDTH'(m_data), LINK_WIDTH'(32'h100 + i));
            checkOutput($sformatf("t2_drain_last%0d", i),  LINK_WIDTH'(m_last), LINK_WIDTH'(i == 7));
            tick();
        end
        checkOutput("t2_empty",      LINK_WIDTH'(m_valid), '0);
        checkOutput("t2_hold_last",  LINK_WIDTH'(m_data), 130'h107);
        tick();
        tick();
        tick();
        checkOutput("t2_ovf_sticky", LINK_WIDTH'(overflow_err), 1);
        checkOutput("t2_pulses",     LINK_WIDTH'(pulses), 9);

        // Full FIFO with push and pop on the same edge.
        $display("[TB] push and pop while full");
        doReset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, DATA_WIDTH'(32'h300 + i));
            tick();
        end
        applyStimulus(1'b1, 1'b0, 128'h308);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t3_occ_before", LINK_WIDTH'(occupancy), 8);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checkOutput("t3_occ",        LINK_WIDTH'(occupancy), 8);
        checkOutput("t3_ovf",        LINK_WIDTH'(overflow_err), '0);
        checkOutput("t3_head",       LINK_WIDTH'(m_data), 130'h301);

        // ap_start low stalls pops and credits while words keep arriving.
        $display("[TB] ap_start stall");
        doReset();
        ap_start = 1'b0;
        m_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, DATA_WIDTH'(32'h400 + i));
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        tick();
        checkOutput("t4_occ",        LINK_WIDTH'(occupancy), 3);
        checkOutput("t4_stalled",    LINK_WIDTH'(m_valid), '0);
        checkOutput("t4_no_credit",  out_to_east, '0);
        ap_start = 1'b1;
        #1;
        checkOutput("t4_resume",     LINK_WIDTH'(m_valid), 1);
        checkOutput("t4_head",       LINK_WIDTH'(m_data), 130'h400);
        tick();
        checkOutput("t4_c0",         out_to_east, '0);
        tick();
        checkOutput("t4_c1",         out_to_east, CREDIT_WORD);
        tick();
        checkOutput("t4_c2",         out_to_east, CREDIT_WORD);
        checkOutput("t4_drained",    LINK_WIDTH'(occupancy), '0);
        tick();
        checkOutput("t4_c3",         out_to_east, CREDIT_WORD);
        tick();
        checkOutput("t4_c4",         out_to_east, '0);
        checkOutput("t4_pulses",     LINK_WIDTH'(pulses), 12);

        // Two pops, then ap_start drops with one credit still pending.
        $display("[TB] pending credits across ap_start drop");
        ap_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, DATA_WIDTH'(32'h500 + i));
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        ap_start = 1'b1;
        tick();
        tick();
        ap_start = 1'b0;
        checkOutput("t5_first",      out_to_east, CREDIT_WORD);
        tick();
        checkOutput("t5_hold0",      out_to_east, '0);
        tick();
        tick();
        checkOutput("t5_hold1",      out_to_east, '0);
        checkOutput("t5_occ",        LINK_WIDTH'(occupancy), '0);
        ap_start = 1'b1;
        tick();
        checkOutput("t5_resume",     out_to_east, CREDIT_WORD);
        tick();
        checkOutput("t5_done",       out_to_east, '0);
        checkOutput("t5_pulses",     LINK_WIDTH'(pulses), 14);

        // Asynchronous reset with five words buffered and one credit unreturned.
        $display("[TB] async reset mid-burst");
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, DATA_WIDTH'(32'h600 + i));
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checkOutput("t6_occ5",       LINK_WIDTH'(occupancy), 5);
        reset = 1'b1;
        #1;
        checkOutput("t6_valid",      LINK_WIDTH'(m_valid), '0);
        checkOutput("t6_occ",        LINK_WIDTH'(occupancy), '0);
        checkOutput("t6_data",       LINK_WIDTH'(m_data), '0);
        checkOutput("t6_last",       LINK_WIDTH'(m_last), '0);
        checkOutput("t6_out",        out_to_east, '0);
        tick();
        reset   = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("t6_no_credit",  LINK_WIDTH'(pulses), 14);
        applyStimulus(1'b1, 1'b0, 128'h777);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t6_new_wait",   LINK_WIDTH'(m_valid), '0);
        tick();
        checkOutput("t6_new_valid",  LINK_WIDTH'(m_valid), 1);
        checkOutput("t6_new_data",   LINK_WIDTH'(m_data), 130'h777);
        tick();
        tick();
        tick();
        checkOutput("t6_pulses",     LINK_WIDTH'(pulses), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
